mcu_reset_sequencer: RTL and testbench

- Board-level controller that sequences reset and halt of the rvsteel_mcu instance from raw, bouncy push-buttons.
- Sits between board pins and the MCU `reset`/`halt` inputs in each board top.
- Replaces the single-flop reset capture with proper synchronization, debouncing and a guaranteed minimum reset pulse.
- Adds a halt toggle button and a run-status output for an LED.

---
 rtl/mcu_reset_sequencer_pkg.sv | 20 ++
 rtl/mcu_reset_sequencer_button_debouncer.sv | 52 +++++
 rtl/mcu_reset_sequencer.sv | 119 +++++++++++
 tb/tb_mcu_reset_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mcu_reset_sequencer_pkg.sv
// Shared board-level definitions: controller state encoding and counter sizing.
// Other board-level controllers may reuse the state encoding.
package mcu_reset_sequencer_pkg;

   localparam logic [1:0] STATE_HOLD = 2'd0;
   localparam logic [1:0] STATE_RUN  = 2'd1;
   localparam logic [1:0] STATE_HALT = 2'd2;

   typedef enum logic [1:0] {
      StHold = STATE_HOLD,
      StRun  = STATE_RUN,
      StHalt = STATE_HALT
   } seq_state_e;

   // One spare bit over $clog2 so a terminal count never wraps.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/mcu_reset_sequencer_button_debouncer.sv
// Raw push-button conditioning: multi-flop synchronizer followed by a
// stability counter that only moves the registered level after a steady run.
module button_debouncer
   import mcu_reset_sequencer_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic button,
   output logic db
);

   localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   db_q, db_d;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], button};
      cnt_d  = '0;
      db_d   = db_q;
      if (synced != db_q) begin
         if (cnt_q == CntLast) begin
            db_d = synced;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         db_q   <= db_d;
      end
   end

   assign db = db_q;

endmodule

// File: rtl/mcu_reset_sequencer.sv
// Board-level reset/halt sequencer for the MCU: debounced buttons, halt toggle
// and a minimum reset hold after every release.
module mcu_reset_sequencer
   import mcu_reset_sequencer_pkg::*;
#(
   parameter int unsigned SYNC_STAGES       = 2,
   parameter int unsigned DEBOUNCE_CYCLES   = 500000,
   parameter int unsigned RESET_HOLD_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic button_reset,
   input  logic button_halt,
   output logic mcu_reset,
   output logic mcu_halt,
   output logic running
);

   localparam int unsigned HoldW = cnt_width(RESET_HOLD_CYCLES);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD_CYCLES - 1);

   logic db_reset, db_halt;
   logic db_halt_q, db_halt_d;
   logic halt_press;

   seq_state_e       state_q, state_d;
   logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
   logic             mcu_reset_q, mcu_reset_d;
   logic             mcu_halt_q, mcu_halt_d;
   logic             running_q, running_d;

   button_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_reset (
      .clock  (clock),
      .reset  (reset),
      .button (button_reset),
      .db     (db_reset)
   );

   button_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_db_halt (
      .clock  (clock),
      .reset  (reset),
      .button (button_halt),
      .db     (db_halt)
   );

   assign db_halt_d  = db_halt;
   assign halt_press = db_halt & ~db_halt_q;

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      unique case (state_q)
         StHold: begin
            if (db_reset) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HoldLast) begin
               state_d    = StRun;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
         end
         StRun: begin
            if (db_reset) begin
               state_d    = StHold;
               hold_cnt_d = '0;
            end else if (halt_press) begin
               state_d = StHalt;
            end
         end
         StHalt: begin
            if (db_reset) begin
               state_d    = StHold;
               hold_cnt_d = '0;
            end else if (halt_press) begin
               state_d = StRun;
            end
         end
         default: begin
            state_d    = StHold;
            hold_cnt_d = '0;
         end
      endcase

      // Decode from next state so outputs move on the same edge as the state.
      mcu_reset_d = (state_d == StHold);
      mcu_halt_d  = (state_d == StHalt);
      running_d   = (state_d == StRun);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StHold;
         hold_cnt_q  <= '0;
         db_halt_q   <= 1'b0;
         mcu_reset_q <= 1'b1;
         mcu_halt_q  <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         db_halt_q   <= db_halt_d;
         mcu_reset_q <= mcu_reset_d;
         mcu_halt_q  <= mcu_halt_d;
         running_q   <= running_d;
      end
   end

   assign mcu_reset = mcu_reset_q;
   assign mcu_halt  = mcu_halt_q;
   assign running   = running_q;

endmodule

// File: tb/tb_mcu_reset_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge
// monitor pops and compares every entry due in the current cycle.
module tb_mcu_reset_sequencer;

  logic clock;
  logic reset;
  logic btn_r;
  logic btn_h;
  logic mcu_reset;
  logic mcu_halt;
  logic running;

  mcu_reset_sequencer #(
    .SYNC_STAGES       (2),
    .DEBOUNCE_CYCLES   (4),
    .RESET_HOLD_CYCLES (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .button_reset (btn_r),
    .button_halt  (btn_h),
    .mcu_reset    (mcu_reset),
    .mcu_halt     (mcu_halt),
    .running      (running)
  );

  typedef struct {
    int    cyc;
    logic  r;
    logic  h;
    logic  run;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc == cyc && mcu_reset === sb[i].r && mcu_halt === sb[i].h &&
            running === sb[i].run) begin
          passed++;
        end else begin
          $display("FAIL %s cyc=%0d got reset/halt/run=%b%b%b exp=%b%b%b (due %0d)",
                   sb[i].name, cyc, mcu_reset, mcu_halt, running,
                   sb[i].r, sb[i].h, sb[i].run, sb[i].cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Expect outputs (r,h,run) after posedges cyc+lo .. cyc+hi.
  task automatic exp_rng(input int lo, input int hi, input logic r, input logic h,
                         input logic run, input string name);
    exp_t e;
    for (int k = lo; k <= hi; k++) begin
      e.cyc  = cyc + k;
      e.r    = r;
      e.h    = h;
      e.run  = run;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  initial begin
    reset = 1'b0;
    btn_r = 1'b0;
    btn_h = 1'b0;
    ticks(3);
    checks++;
    if (mcu_reset === 1'b1 && mcu_halt === 1'b0 && running === 1'b0) begin
      passed++;
    end else begin
      $display("FAIL direct_por got %b%b%b", mcu_reset, mcu_halt, running);
    end
    exp_rng(0, 0, 1, 0, 0, "por");
    reset = 1'b1;
    exp_rng(1, 7, 1, 0, 0, "por_hold");
    exp_rng(8, 10, 0, 0, 1, "por_run");
    ticks(10);
    checks++;
    if (mcu_reset === 1'b0 && mcu_halt === 1'b0 && running === 1'b1) begin
      passed++;
    end else begin
      $display("FAIL direct_run got %b%b%b", mcu_reset, mcu_halt, running);
    end

    // Short halt glitch never reaches the debounced level.
    btn_h = 1'b1;
    exp_rng(1, 12, 0, 0, 1, "halt_glitch");
    ticks(3);
    btn_h = 1'b0;
    ticks(12);

    // Held halt press: toggles once, 7 cycles after the raw rise.
    btn_h = 1'b1;
    exp_rng(1, 6, 0, 0, 1, "halt_pre");
    exp_rng(7, 22, 0, 1, 0, "halt_on");
    ticks(10);
    btn_h = 1'b0;
    ticks(14);

    btn_h = 1'b1;
    exp_rng(1, 6, 0, 1, 0, "resume_pre");
    exp_rng(7, 22, 0, 0, 1, "resume_on");
    ticks(10);
    btn_h = 1'b0;
    ticks(14);

    btn_h = 1'b1;
    exp_rng(1, 6, 0, 0, 1, "halt2_pre");
    exp_rng(7, 22, 0, 1, 0, "halt2_on");
    ticks(10);
    btn_h = 1'b0;
    ticks(14);

    // Reset press from HALT: held 20, db falls at +26, RUN at +34.
    btn_r = 1'b1;
    exp_rng(1, 6, 0, 1, 0, "rst_pre");
    exp_rng(7, 33, 1, 0, 0, "rst_hold");
    exp_rng(34, 36, 0, 0, 1, "rst_run");
    ticks(20);
    btn_r = 1'b0;
    ticks(18);

    // Bouncy reset button, runs of 2 cycles.
    exp_rng(1, 40, 0, 0, 1, "bounce");
    for (int i = 0; i < 15; i++) begin
      btn_r = (i % 2 == 0);
      ticks(2);
    end
    btn_r = 1'b0;
    ticks(12);

    // Simultaneous reset and halt presses: reset wins.
    btn_r = 1'b1;
    btn_h = 1'b1;
    exp_rng(1, 6, 0, 0, 1, "sim_pre");
    exp_rng(7, 23, 1, 0, 0, "sim_hold");
    exp_rng(24, 26, 0, 0, 1, "sim_run");
    ticks(10);
    btn_r = 1'b0;
    btn_h = 1'b0;
    ticks(18);

    btn_h = 1'b1;
    exp_rng(1, 6, 0, 0, 1, "halt3_pre");
    exp_rng(7, 14, 0, 1, 0, "halt3_on");
    ticks(10);
    btn_h = 1'b0;
    ticks(8);

    // Async reset in HALT while a halt press is mid-debounce.
    btn_h = 1'b1;
    exp_rng(1, 2, 0, 1, 0, "mid_pre");
    ticks(3);
    reset = 1'b0;
    #1;
    checks++;
    if (mcu_reset === 1'b1 && mcu_halt === 1'b0 && running === 1'b0) begin
      passed++;
    end else begin
      $display("FAIL direct_async got %b%b%b", mcu_reset, mcu_halt, running);
    end
    exp_rng(0, 2, 1, 0, 0, "async_rst");
    ticks(1);
    btn_h = 1'b0;
    ticks(2);
    reset = 1'b1;
    exp_rng(0, 7, 1, 0, 0, "rel_hold");
    exp_rng(8, 20, 0, 0, 1, "rel_run");
    ticks(22);

    for (int k = 0; k < 200 && sb.size() != 0; k++) ticks(1);
    while (sb.size() != 0) begin
      checks++;
      $display("FAIL %s never checked, due cyc=%0d now %0d", sb[0].name, sb[0].cyc, cyc);
      sb.delete(0);
    end

    if (passed == checks) begin
      $display("PASS: %0d/%0d checks passed", passed, checks);
    end else begin
      $display("FAIL: %0d/%0d checks passed", passed, checks);
    end
    $finish;
  end

endmodule
